// File: rtl/cpu_top.sv
// Single-cycle 32-bit CPU with a 32x32 register file and 64K-word program/data memories.
// Memories read combinationally and write on the rising edge; preloadable through their memory arrays.

module cpu_program_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_enable,
    input  logic        io_jump,
    input  logic [15:0] io_programCounterJump,
    output logic [15:0] io_programCounter
);
    logic [15:0] r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= 16'd0;
        end else if (io_jump) begin
            r_pc <= io_programCounterJump;
        end else if (io_enable) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    assign io_programCounter = r_pc;
endmodule

module cpu_register_file (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  io_in_aSel,
    input  logic [4:0]  io_in_bSel,
    input  logic [4:0]  io_in_writeSel,
    input  logic        io_in_writeEnable,
    input  logic [31:0] io_in_writeData,
    output logic [31:0] io_out_a,
    output logic [31:0] io_out_b
);
    logic [31:0] r_regs [32];
    logic [31:0] regfile_31;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (io_in_writeEnable) begin
            r_regs[io_in_writeSel] <= io_in_writeData;
        end
    end

    assign io_out_a   = r_regs[io_in_aSel];
    assign io_out_b   = r_regs[io_in_bSel];
    assign regfile_31 = r_regs[31];
endmodule

module cpu_memory (
    input  logic        clock,
    input  logic        io_writeEnable,
    input  logic [15:0] io_address,
    input  logic [31:0] io_writeData,
    output logic [31:0] io_dataRead
);
    logic [31:0] memory [65536];

    always_ff @(posedge clock) begin
        if (io_writeEnable) begin
            memory[io_address] <= io_writeData;
        end
    end

    assign io_dataRead = memory[io_address];
endmodule

module cpu_top (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_run,
    output logic        io_done,
    input  logic        io_testerDataMemEnable,
    input  logic        io_testerProgMemEnable,
    input  logic [15:0] io_programMemoryOffset,
    input  logic [15:0] io_dataMemoryOffset
);
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LI   = 6'd5;
    localparam logic [5:0] OP_LD   = 6'd6;
    localparam logic [5:0] OP_SD   = 6'd7;
    localparam logic [5:0] OP_JMP  = 6'd8;
    localparam logic [5:0] OP_BEQ  = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_END  = 6'd11;

    logic        r_done;
    logic [15:0] w_pc;
    logic [15:0] w_fetch_addr;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_ra;
    logic [4:0]  w_rb;
    logic [15:0] w_imm;
    logic [4:0]  w_b_sel;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [15:0] w_ea;
    logic [31:0] w_dmem_rdata;
    logic        w_exec;
    logic        w_reg_we;
    logic [31:0] w_reg_wdata;
    logic        w_dmem_we;
    logic        w_jump;
    logic        w_end;

    // Reset and any stall condition suppress execution entirely.
    assign w_exec = io_run && !r_done && !io_testerDataMemEnable
                    && !io_testerProgMemEnable && !reset;

    assign w_fetch_addr = w_pc + io_programMemoryOffset;
    assign w_op  = w_instr[31:26];
    assign w_rd  = w_instr[25:21];
    assign w_ra  = w_instr[20:16];
    assign w_rb  = w_instr[15:11];
    assign w_imm = w_instr[15:0];

    // SD and branches need reg[rd] on the second read port instead of reg[rb].
    assign w_b_sel = (w_op == OP_SD || w_op == OP_BEQ || w_op == OP_BNE) ? w_rd : w_rb;
    assign w_ea    = w_a[15:0] + w_imm + io_dataMemoryOffset;

    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_wdata = 32'd0;
        w_dmem_we   = 1'b0;
        w_jump      = 1'b0;
        w_end       = 1'b0;
        if (w_exec) begin
            case (w_op)
                OP_ADD:  begin w_reg_we = 1'b1; w_reg_wdata = w_a + w_b; end
                OP_SUB:  begin w_reg_we = 1'b1; w_reg_wdata = w_a - w_b; end
                OP_AND:  begin w_reg_we = 1'b1; w_reg_wdata = w_a & w_b; end
                OP_OR:   begin w_reg_we = 1'b1; w_reg_wdata = w_a | w_b; end
                OP_ADDI: begin w_reg_we = 1'b1; w_reg_wdata = w_a + {{16{w_imm[15]}}, w_imm}; end
                OP_LI:   begin w_reg_we = 1'b1; w_reg_wdata = {16'd0, w_imm}; end
                OP_LD:   begin w_reg_we = 1'b1; w_reg_wdata = w_dmem_rdata; end
                OP_SD:   w_dmem_we = 1'b1;
                OP_JMP:  w_jump = 1'b1;
                OP_BEQ:  w_jump = (w_b == w_a);
                OP_BNE:  w_jump = (w_b != w_a);
                OP_END:  w_end = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_end) begin
            r_done <= 1'b1;
        end
    end

    assign io_done = r_done;

    cpu_program_counter programCounter (
        .clock                 (clock),
        .reset                 (reset),
        .io_enable             (w_exec && !w_end),
        .io_jump               (w_jump),
        .io_programCounterJump (w_imm),
        .io_programCounter     (w_pc)
    );

    cpu_register_file registerFile (
        .clock             (clock),
        .reset             (reset),
        .io_in_aSel        (w_ra),
        .io_in_bSel        (w_b_sel),
        .io_in_writeSel    (w_rd),
        .io_in_writeEnable (w_reg_we),
        .io_in_writeData   (w_reg_wdata),
        .io_out_a          (w_a),
        .io_out_b          (w_b)
    );

    cpu_memory programMemory (
        .clock          (clock),
        .io_writeEnable (1'b0),
        .io_address     (w_fetch_addr),
        .io_writeData   (32'd0),
        .io_dataRead    (w_instr)
    );

    cpu_memory dataMemory (
        .clock          (clock),
        .io_writeEnable (w_dmem_we),
        .io_address     (w_ea),
        .io_writeData   (w_b),
        .io_dataRead    (w_dmem_rdata)
    );
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed programs plus random programs checked against an ISA-level interpreter.

module tb_cpu_top;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_run = 1'b0;
    logic        io_done;
    logic        io_testerDataMemEnable = 1'b0;
    logic        io_testerProgMemEnable = 1'b0;
    logic [15:0] io_programMemoryOffset = 16'd0;
    logic [15:0] io_dataMemoryOffset = 16'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference machine state, kept at instruction-set level.
    logic [31:0] m_regs [32];
    logic [15:0] m_pc;
    logic        m_done;
    logic [31:0] m_dmem [65536];
    logic [31:0] m_prog [65536];

    cpu_top dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_run                 (io_run),
        .io_done                (io_done),
        .io_testerDataMemEnable (io_testerDataMemEnable),
        .io_testerProgMemEnable (io_testerProgMemEnable),
        .io_programMemoryOffset (io_programMemoryOffset),
        .io_dataMemoryOffset    (io_dataMemoryOffset)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input int op, input int rd, input int ra, input int imm);
        logic [5:0]  f_op = 6'(op);
        logic [4:0]  f_rd = 5'(rd);
        logic [4:0]  f_ra = 5'(ra);
        logic [15:0] f_im = 16'(imm);
        return {f_op, f_rd, f_ra, f_im};
    endfunction

    function automatic logic [31:0] enc_r(input int op, input int rd, input int ra, input int rb);
        return enc(op, rd, ra, rb << 11);
    endfunction

    task automatic put_prog(input logic [15:0] a, input logic [31:0] w);
        dut.programMemory.memory[a] = w;
        m_prog[a] = w;
    endtask

    task automatic put_data(input logic [15:0] a, input logic [31:0] w);
        dut.dataMemory.memory[a] = w;
        m_dmem[a] = w;
    endtask

    // One clock: sample jump before the edge, advance the model, then settle past the edge.
    task automatic tick(output logic obs_jump, output logic exp_jump);
        logic [31:0] instr, va, vb, vd;
        logic [5:0]  op;
        logic [4:0]  rd, ra, rb;
        logic [15:0] imm, ea;
        logic        is_end;
        @(negedge clock);
        obs_jump = dut.programCounter.io_jump;
        exp_jump = 1'b0;
        if (reset) begin
            m_pc = 16'd0;
            m_done = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (io_run && !m_done && !io_testerDataMemEnable && !io_testerProgMemEnable) begin
            instr = m_prog[16'(m_pc + io_programMemoryOffset)];
            op = instr[31:26]; rd = instr[25:21]; ra = instr[20:16]; rb = instr[15:11];
            imm = instr[15:0];
            va = m_regs[ra]; vb = m_regs[rb]; vd = m_regs[rd];
            ea = 16'(va[15:0] + imm + io_dataMemoryOffset);
            is_end = 1'b0;
            case (int'(op))
                0:  m_regs[rd] = va + vb;
                1:  m_regs[rd] = va - vb;
                2:  m_regs[rd] = va & vb;
                3:  m_regs[rd] = va | vb;
                4:  m_regs[rd] = va + 32'($signed(imm));
                5:  m_regs[rd] = 32'(imm);
                6:  m_regs[rd] = m_dmem[ea];
                7:  m_dmem[ea] = vd;
                8:  exp_jump = 1'b1;
                9:  exp_jump = (vd == va);
                10: exp_jump = (vd != va);
                11: begin is_end = 1'b1; m_done = 1'b1; end
                default: ;
            endcase
            if (exp_jump) m_pc = imm;
            else if (!is_end) m_pc = m_pc + 16'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_ticks(input int n, output int jumps);
        logic oj, ej;
        jumps = 0;
        for (int i = 0; i < n; i++) begin
            tick(oj, ej);
            if (oj === 1'b1) jumps++;
        end
    endtask

    task automatic do_reset();
        logic oj, ej;
        reset = 1'b1;
        tick(oj, ej);
        reset = 1'b0;
    endtask

    task automatic load_alu_prog();
        put_prog(16'd0, enc(5, 1, 0, 5));
        put_prog(16'd1, enc(5, 2, 0, 7));
        put_prog(16'd2, enc_r(0, 3, 1, 2));
        put_prog(16'd3, enc_r(1, 4, 1, 2));
        put_prog(16'd4, enc(11, 0, 0, 0));
    endtask

    task automatic test_reset();
        int j;
        io_run = 1'b0;
        reset = 1'b1;
        run_ticks(2, j);
        reset = 1'b0;
        n_cmp++;
        if (dut.programCounter.io_programCounter !== 16'd0) begin
            n_bad++; $display("FAIL reset_pc: got %h want 0000", dut.programCounter.io_programCounter);
        end
        n_cmp++;
        if (io_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", io_done); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.registerFile.r_regs[i] !== 32'd0) begin
                n_bad++; $display("FAIL reset_reg%0d: got %h want 0", i, dut.registerFile.r_regs[i]);
            end
        end
    endtask

    task automatic test_alu();
        int j;
        io_run = 1'b0; io_programMemoryOffset = 16'd0; io_dataMemoryOffset = 16'd0;
        load_alu_prog();
        do_reset();
        io_run = 1'b1;
        run_ticks(4, j);
        n_cmp++;
        if (io_done !== 1'b0) begin n_bad++; $display("FAIL alu_done_early: got %b want 0", io_done); end
        run_ticks(1, j);
        n_cmp++;
        if (io_done !== 1'b1) begin n_bad++; $display("FAIL alu_done: got %b want 1", io_done); end
        n_cmp++;
        if (dut.registerFile.r_regs[3] !== 32'd12) begin
            n_bad++; $display("FAIL alu_r3: got %h want 0000000c", dut.registerFile.r_regs[3]);
        end
        n_cmp++;
        if (dut.registerFile.r_regs[4] !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL alu_r4: got %h want fffffffe", dut.registerFile.r_regs[4]);
        end
        run_ticks(3, j);
        n_cmp++;
        if (dut.programCounter.io_programCounter !== 16'd4) begin
            n_bad++; $display("FAIL alu_pc_hold: got %h want 0004", dut.programCounter.io_programCounter);
        end
    endtask

    task automatic test_load_store();
        int j;
        io_run = 1'b0;
        put_data(16'h0010, 32'h0000_DEAD);
        put_data(16'h0011, 32'd0);
        put_prog(16'd0, enc(6, 1, 0, 16'h10));
        put_prog(16'd1, enc(7, 1, 0, 16'h11));
        put_prog(16'd2, enc(11, 0, 0, 0));
        do_reset();
        io_run = 1'b1;
        run_ticks(4, j);
        n_cmp++;
        if (dut.dataMemory.memory[16'h0011] !== 32'h0000_DEAD) begin
            n_bad++; $display("FAIL ls_dmem11: got %h want 0000dead", dut.dataMemory.memory[16'h0011]);
        end
        n_cmp++;
        if (dut.registerFile.r_regs[1] !== 32'h0000_DEAD) begin
            n_bad++; $display("FAIL ls_r1: got %h want 0000dead", dut.registerFile.r_regs[1]);
        end
    endtask

    task automatic test_control_flow();
        int j;
        io_run = 1'b0;
        put_prog(16'd0, enc(5, 1, 0, 3));
        put_prog(16'd1, enc(4, 1, 1, 16'hFFFF));
        put_prog(16'd2, enc(10, 1, 0, 1));
        put_prog(16'd3, enc(11, 0, 0, 0));
        do_reset();
        io_run = 1'b1;
        run_ticks(10, j);
        n_cmp++;
        if (j !== 2) begin n_bad++; $display("FAIL cf_jumps: got %0d want 2", j); end
        n_cmp++;
        if (dut.registerFile.r_regs[1] !== 32'd0) begin
            n_bad++; $display("FAIL cf_r1: got %h want 0", dut.registerFile.r_regs[1]);
        end
        n_cmp++;
        if (io_done !== 1'b1 || dut.programCounter.io_programCounter !== 16'd3) begin
            n_bad++; $display("FAIL cf_end: got done=%b pc=%h want done=1 pc=0003",
                              io_done, dut.programCounter.io_programCounter);
        end
    endtask

    task automatic test_offsets();
        int j;
        io_run = 1'b0;
        put_data(16'h0020, 32'd0);
        put_data(16'h0000, 32'd0);
        put_prog(16'h0100, enc(5, 5, 0, 16'hBEEF));
        put_prog(16'h0101, enc(7, 5, 0, 0));
        put_prog(16'h0102, enc(11, 0, 0, 0));
        load_alu_prog();
        do_reset();
        io_programMemoryOffset = 16'h0100;
        io_dataMemoryOffset = 16'h0020;
        io_run = 1'b1;
        run_ticks(3, j);
        n_cmp++;
        if (io_done !== 1'b1 || dut.programCounter.io_programCounter !== 16'd2) begin
            n_bad++; $display("FAIL off_fetch: got done=%b pc=%h want done=1 pc=0002",
                              io_done, dut.programCounter.io_programCounter);
        end
        n_cmp++;
        if (dut.dataMemory.memory[16'h0020] !== 32'h0000_BEEF) begin
            n_bad++; $display("FAIL off_dmem20: got %h want 0000beef", dut.dataMemory.memory[16'h0020]);
        end
        n_cmp++;
        if (dut.dataMemory.memory[16'h0000] !== 32'd0) begin
            n_bad++; $display("FAIL off_dmem0: got %h want 0", dut.dataMemory.memory[16'h0000]);
        end
        io_programMemoryOffset = 16'd0;
        io_dataMemoryOffset = 16'd0;
    endtask

    task automatic test_stall();
        int j;
        io_run = 1'b0;
        load_alu_prog();
        do_reset();
        io_run = 1'b1;
        run_ticks(2, j);
        for (int k = 0; k < 3; k++) begin
            io_run = (k != 0);
            io_testerDataMemEnable = (k == 1);
            io_testerProgMemEnable = (k == 2);
            run_ticks(3, j);
            n_cmp++;
            if (dut.programCounter.io_programCounter !== 16'd2 || dut.registerFile.r_regs[3] !== 32'd0
                || dut.registerFile.r_regs[2] !== 32'd7) begin
                n_bad++; $display("FAIL stall_%0d: got pc=%h r3=%h r2=%h want pc=0002 r3=0 r2=7", k,
                                  dut.programCounter.io_programCounter, dut.registerFile.r_regs[3],
                                  dut.registerFile.r_regs[2]);
            end
        end
        io_testerDataMemEnable = 1'b0;
        io_testerProgMemEnable = 1'b0;
        io_run = 1'b1;
        run_ticks(3, j);
        n_cmp++;
        if (io_done !== 1'b1 || dut.registerFile.r_regs[3] !== 32'd12) begin
            n_bad++; $display("FAIL stall_resume: got done=%b r3=%h want done=1 r3=c",
                              io_done, dut.registerFile.r_regs[3]);
        end
    endtask

    task automatic test_reset_rerun();
        int j;
        io_run = 1'b1;
        reset = 1'b1;
        run_ticks(1, j);
        reset = 1'b0;
        n_cmp++;
        if (io_done !== 1'b0 || dut.programCounter.io_programCounter !== 16'd0
            || dut.registerFile.r_regs[3] !== 32'd0) begin
            n_bad++; $display("FAIL rerun_reset: got done=%b pc=%h r3=%h want 0 0 0", io_done,
                              dut.programCounter.io_programCounter, dut.registerFile.r_regs[3]);
        end
        run_ticks(4, j);
        reset = 1'b1;
        run_ticks(1, j);
        reset = 1'b0;
        n_cmp++;
        if (io_done !== 1'b0 || dut.programCounter.io_programCounter !== 16'd0) begin
            n_bad++; $display("FAIL reset_over_end: got done=%b pc=%h want done=0 pc=0000",
                              io_done, dut.programCounter.io_programCounter);
        end
        run_ticks(5, j);
        n_cmp++;
        if (io_done !== 1'b1 || dut.registerFile.r_regs[3] !== 32'd12) begin
            n_bad++; $display("FAIL rerun_done: got done=%b r3=%h want done=1 r3=c",
                              io_done, dut.registerFile.r_regs[3]);
        end
    endtask

    task automatic test_random();
        localparam int N = 48;
        logic oj, ej;
        logic [15:0] base;
        int k, bad_mem;
        for (int a = 0; a < 65536; a++) put_data(16'(a), $urandom);
        for (int p = 0; p < 8; p++) begin
            base = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                k = $urandom_range(0, 15);
                case (k)
                    0, 1, 2, 3: put_prog(16'(base + i), enc_r(k, $urandom_range(0, 7),
                                                         $urandom_range(0, 7), $urandom_range(0, 7)));
                    4, 5:  put_prog(16'(base + i), enc(k, $urandom_range(0, 7), $urandom_range(0, 7),
                                                       $urandom_range(0, 65535)));
                    6, 7:  put_prog(16'(base + i), enc(k, $urandom_range(0, 7), $urandom_range(0, 7),
                                                       $urandom_range(0, 65535)));
                    8, 9, 10: put_prog(16'(base + i), enc(k, $urandom_range(0, 7), $urandom_range(0, 7),
                                                          $urandom_range(0, N)));
                    11: put_prog(16'(base + i), ($urandom_range(0, 5) == 0) ? enc(11, 0, 0, 0)
                                 : enc($urandom_range(12, 63), $urandom_range(0, 31), 0, $urandom));
                    default: put_prog(16'(base + i), enc(5, ($urandom_range(0, 3) == 0) ? 31
                                                         : $urandom_range(0, 7), 0, $urandom));
                endcase
            end
            put_prog(16'(base + N), enc(11, 0, 0, 0));
            io_run = 1'b0;
            io_programMemoryOffset = base;
            do_reset();
            for (int c = 0; c < 150; c++) begin
                reset = ($urandom_range(0, 59) == 0);
                io_run = ($urandom_range(0, 9) != 0);
                io_testerDataMemEnable = ($urandom_range(0, 19) == 0);
                io_testerProgMemEnable = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) io_dataMemoryOffset = 16'($urandom);
                tick(oj, ej);
                n_cmp++;
                if (oj !== ej) begin n_bad++; $display("FAIL rnd_jump p%0d c%0d: got %b want %b", p, c, oj, ej); end
                n_cmp++;
                if (dut.programCounter.io_programCounter !== m_pc || io_done !== m_done
                    || dut.registerFile.regfile_31 !== m_regs[31]) begin
                    n_bad++; $display("FAIL rnd_state p%0d c%0d: got pc=%h done=%b r31=%h want pc=%h done=%b r31=%h",
                                      p, c, dut.programCounter.io_programCounter, io_done,
                                      dut.registerFile.regfile_31, m_pc, m_done, m_regs[31]);
                end
            end
            reset = 1'b0;
            io_run = 1'b0;
            io_testerDataMemEnable = 1'b0;
            io_testerProgMemEnable = 1'b0;
            for (int r = 0; r < 32; r++) begin
                n_cmp++;
                if (dut.registerFile.r_regs[r] !== m_regs[r]) begin
                    n_bad++; $display("FAIL rnd_reg p%0d r%0d: got %h want %h", p, r,
                                      dut.registerFile.r_regs[r], m_regs[r]);
                end
            end
            bad_mem = 0;
            for (int a = 0; a < 65536; a++) begin
                if (dut.dataMemory.memory[a] !== m_dmem[a]) bad_mem++;
            end
            n_cmp++;
            if (bad_mem != 0) begin n_bad++; $display("FAIL rnd_dmem p%0d: got %0d differing words want 0", p, bad_mem); end
        end
        io_programMemoryOffset = 16'd0;
        io_dataMemoryOffset = 16'd0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            put_prog(16'(a), 32'd0);
            put_data(16'(a), 32'd0);
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 16'd0;
        m_done = 1'b0;
        test_reset();
        test_alu();
        test_load_store();
        test_control_flow();
        test_offsets();
        test_stall();
        test_reset_rerun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameters SHALL be: none; all widths are fixed as stated below.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_run  input  1  1 = execute one instruction per cycle; 0 = hold all state.
REQ-005 io_done  output  1  registered, sticky; 1 after an END instruction has executed.
REQ-006 io_testerDataMemEnable  input  1  1 = data memory is owned by the external tester; CPU is stalled.
REQ-007 io_testerProgMemEnable  input  1  1 = program memory is owned by the external tester; CPU is stalled.
REQ-008 io_programMemoryOffset  input  16  added to PC to form the fetch address.
REQ-009 io_dataMemoryOffset  input  16  added to the effective address of LD/SD.

Function
REQ-010 Storage SHALL be:
- 32 general registers of 32 bits, all writable, none hardwired;
- a 16-bit PC;
- program memory of 65536 x 32-bit words;
- data memory of 65536 x 32-bit words.
REQ-011 Both memories SHALL use combinational read and synchronous write, and SHALL be preloadable through the hierarchical memory arrays programMemory.memory and dataMemory.memory.
REQ-012 Execution SHALL be single-cycle: one instruction executes when io_run=1, io_done=0 and both tester enables are 0; otherwise all state holds.
REQ-013 Fetch address SHALL be (PC + io_programMemoryOffset) mod 2^16.
REQ-014 Instruction fields SHALL be:
- op = [31:26]
- rd = [25:21]
- ra = [20:16]
- rb = [15:11]
- imm = [15:0]
REQ-015 Opcodes SHALL be (results are 32-bit, wrap-around, no flags):
- 0 ADD: rd = ra + rb
- 1 SUB: rd = ra - rb
- 2 AND: rd = ra & rb
- 3 OR: rd = ra | rb
- 4 ADDI: rd = ra + signext(imm)
- 5 LI: rd = zeroext(imm)
- 6 LD: rd = dmem[ea]
- 7 SD: dmem[ea] = reg[rd]
- 8 JMP: PC = imm
- 9 BEQ: if reg[rd] == reg[ra] then PC = imm
- 10 BNE: if reg[rd] != reg[ra] then PC = imm
- 11 END: set io_done
- 12-63: NOP
REQ-016 Effective address ea SHALL be (reg[ra][15:0] + imm + io_dataMemoryOffset) mod 2^16.
REQ-017 Register reads SHALL be combinational; a write lands at the clock edge, so a read in the same cycle sees the old value.
REQ-018 PC SHALL become PC+1 (wrapping 65535 -> 0) unless a jump or taken branch loads imm. Jump targets are not offset-adjusted; the offset applies only at fetch.
REQ-019 END SHALL set io_done at the executing edge. PC SHALL NOT advance for END. Once io_done=1 the CPU SHALL execute nothing further until reset.
REQ-020 Offsets SHALL be sampled combinationally in the cycle of use; a change takes effect on the next executed instruction.
REQ-021 Internal signals SHALL be exposed with exactly these hierarchical names so a bench can monitor them:
- programCounter.io_programCounter
- programCounter.io_jump: 1 in a cycle that executes JMP or a taken branch
- programCounter.io_programCounterJump: imm
- registerFile.io_in_aSel, registerFile.io_in_bSel
- registerFile.io_in_writeSel, registerFile.io_in_writeEnable
- registerFile.regfile_31
- dataMemory.io_address: ea

Reset
REQ-022 When reset=1 at a rising edge:
- PC = 0, io_done = 0, all 32 registers = 0;
- memory contents are untouched;
- no instruction executes in that cycle.
REQ-023 Reset asserted mid-program SHALL take priority over execution and END in the same cycle.

Verification
REQ-024 ALU and immediates: LI r1,5; LI r2,7; ADD r3,r1,r2; SUB r4,r1,r2; END -> r3=12, r4=0xFFFFFFFE, io_done=1 after 5 executed cycles.
REQ-025 Load/store: dmem[0x10]=0xDEAD; LD r1,r0+0x10; SD r1 -> 0x11; END -> dmem[0x11]=0xDEAD.
REQ-026 Control flow: LI r1,3; ADDI r1,r1,-1; BNE r1,r0 -> 1; END -> loop taken twice, r1=0, io_jump pulses twice.
REQ-027 Offsets: io_programMemoryOffset=0x100 with the program placed at 0x100, and io_dataMemoryOffset=0x20 with SD to ea base 0 -> fetch from 0x100, write lands at dmem[0x20].
REQ-028 Stall and reset:
- io_run=0 or either tester enable=1 for 3 cycles -> PC and registers unchanged;
- reset pulsed after io_done=1 -> io_done=0, PC=0, and the program reruns.
